// File: rtl/sound_pkg.sv
// Shared constants for the Direct Sound FIFO block: bus addresses, SOUNDCNT_H
// bit positions, default geometry and a little-endian byte extractor.
package sound_pkg;

  localparam int unsigned SND_DEPTH_WORDS = 8;
  localparam int unsigned SND_REQ_LEVEL   = 16;

  localparam logic [31:0] SND_FIFO_A_ADDR = 32'h0400_00A0;
  localparam logic [31:0] SND_FIFO_B_ADDR = 32'h0400_00A4;
  localparam logic [1:0]  SND_SIZE_WORD   = 2'b10;

  localparam int unsigned SNDH_A_TMR = 10;
  localparam int unsigned SNDH_A_RST = 11;
  localparam int unsigned SNDH_B_TMR = 14;
  localparam int unsigned SNDH_B_RST = 15;

  // Byte 0 is the first sample to play out of a buffered word.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sound_fifo_channel.sv
// One Direct Sound channel: word-wide writes, byte-wide pops, occupancy count
// and a once-per-refill request pulse gated by a pending flag.
module sound_fifo_channel
  import sound_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = SND_DEPTH_WORDS,
  parameter int unsigned REQ_LEVEL   = SND_REQ_LEVEL,
  localparam int unsigned PTR_W      = $clog2(DEPTH_WORDS),
  localparam int unsigned BPTR_W     = PTR_W + 2,
  localparam int unsigned CNT_W      = $clog2(DEPTH_WORDS * 4 + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push,
  input  logic [31:0]      push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [7:0]       sample,
  output logic [CNT_W-1:0] count,
  output logic             req
);

  localparam logic [CNT_W-1:0] PUSH_LIMIT = CNT_W'(DEPTH_WORDS * 4 - 4);
  localparam logic [CNT_W-1:0] REQ_LIMIT  = CNT_W'(REQ_LEVEL);

  logic [31:0]       mem_q [DEPTH_WORDS];
  logic [31:0]       mem_d [DEPTH_WORDS];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [BPTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        sample_q, sample_d;
  logic              pending_q, pending_d;
  logic              req_q, req_d;
  logic              push_ok_s, pop_ok_s;

  // Next-state: eligibility is judged on the pre-cycle count, so a pop from an
  // empty FIFO never sees a same-cycle write.
  always_comb begin
    push_ok_s = push & ~flush & (count_q <= PUSH_LIMIT);
    pop_ok_s  = pop & ~flush & (count_q != {CNT_W{1'b0}});
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    sample_d  = sample_q;
    pending_d = pending_q;
    req_d     = 1'b0;
    if (flush) begin
      wptr_d    = {PTR_W{1'b0}};
      rptr_d    = {BPTR_W{1'b0}};
      count_d   = {CNT_W{1'b0}};
      sample_d  = 8'h00;
      pending_d = 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_d[wptr_q] = push_data;
        wptr_d        = wptr_q + PTR_W'(1'b1);
        count_d       = count_d + CNT_W'(3'd4);
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_ok_s) begin
        sample_d = word_byte(mem_q[rptr_q[BPTR_W-1:2]], rptr_q[1:0]);
        rptr_d   = rptr_q + BPTR_W'(1'b1);
        count_d  = count_d - CNT_W'(1'b1);
      end else begin
        rptr_d = rptr_q;
      end
      // Setting pending outranks a same-cycle write clearing it.
      if (pop_ok_s && (count_d <= REQ_LIMIT) && !pending_q) begin
        pending_d = 1'b1;
        req_d     = 1'b1;
      end else if (push_ok_s) begin
        pending_d = 1'b0;
      end else begin
        pending_d = pending_q;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wptr_q    <= {PTR_W{1'b0}};
      rptr_q    <= {BPTR_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
      sample_q  <= 8'h00;
      pending_q <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      sample_q  <= sample_d;
      pending_q <= pending_d;
      req_q     <= req_d;
    end
  end

  // Sample storage; contents are meaningless whenever count is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign sample = sample_q;
  assign count  = count_q;
  assign req    = req_q;

endmodule

// File: rtl/direct_sound_fifo.sv
// Direct Sound A/B buffer: decodes FIFO writes, routes the selected timer
// overflow to each channel and merges the refill requests for the DMA block.
module direct_sound_fifo
  import sound_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = SND_DEPTH_WORDS,
  parameter int unsigned REQ_LEVEL   = SND_REQ_LEVEL,
  parameter logic [31:0] FIFO_A_ADDR = SND_FIFO_A_ADDR,
  parameter logic [31:0] FIFO_B_ADDR = SND_FIFO_B_ADDR
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        wen,
  input  logic        mem_wait,
  input  logic [15:0] soundcnt_h,
  input  logic        timer0_ovf,
  input  logic        timer1_ovf,
  output logic [7:0]  sample_a,
  output logic [7:0]  sample_b,
  output logic        sound_req_a,
  output logic        sound_req_b,
  output logic        sound_req,
  output logic [5:0]  count_a,
  output logic [5:0]  count_b
);

  logic word_wr_s;
  logic push_a_s, push_b_s;
  logic pop_a_s, pop_b_s;
  logic flush_a_s, flush_b_s;
  logic unused_sndh_s;

  // Bus decode and timer routing.
  always_comb begin
    word_wr_s = wen & ~mem_wait & (size == SND_SIZE_WORD);
    push_a_s  = word_wr_s & (addr == FIFO_A_ADDR);
    push_b_s  = word_wr_s & (addr == FIFO_B_ADDR);
    pop_a_s   = soundcnt_h[SNDH_A_TMR] ? timer1_ovf : timer0_ovf;
    pop_b_s   = soundcnt_h[SNDH_B_TMR] ? timer1_ovf : timer0_ovf;
    flush_a_s = soundcnt_h[SNDH_A_RST];
    flush_b_s = soundcnt_h[SNDH_B_RST];
  end

  // Volume and enable fields belong to the mixer, not this block.
  assign unused_sndh_s = ^{soundcnt_h[13:12], soundcnt_h[9:0]};

  sound_fifo_channel #(.DEPTH_WORDS(DEPTH_WORDS), .REQ_LEVEL(REQ_LEVEL)) u_chan_a (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (push_a_s),
    .push_data (wdata),
    .pop       (pop_a_s),
    .flush     (flush_a_s),
    .sample    (sample_a),
    .count     (count_a),
    .req       (sound_req_a)
  );

  sound_fifo_channel #(.DEPTH_WORDS(DEPTH_WORDS), .REQ_LEVEL(REQ_LEVEL)) u_chan_b (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (push_b_s),
    .push_data (wdata),
    .pop       (pop_b_s),
    .flush     (flush_b_s),
    .sample    (sample_b),
    .count     (count_b),
    .req       (sound_req_b)
  );

  // Both inputs are flop outputs, so the merged request stays glitch-free.
  assign sound_req = sound_req_a | sound_req_b;

endmodule

// File: tb/tb_direct_sound_fifo.sv
// Directed bench for direct_sound_fifo: a vector table for channel A plus
// hand-written sequences for B fill/wrap, channel reset and async reset.
module tb_direct_sound_fifo;

  logic        clk;
  logic        rst_b;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        wen;
  logic        mem_wait;
  logic [15:0] soundcnt_h;
  logic        timer0_ovf;
  logic        timer1_ovf;
  logic [7:0]  sample_a, sample_b;
  logic        sound_req_a, sound_req_b, sound_req;
  logic [5:0]  count_a, count_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum logic [3:0] {
    OP_IDLE, OP_WR_A, OP_WR_B, OP_POP0, OP_POP1,
    OP_WR_A_POP0, OP_WR_A_HALF, OP_WR_A_WAIT, OP_WR_BAD
  } op_e;

  typedef struct {
    op_e         op;
    logic [31:0] data;
    logic [15:0] sndh;
    logic [7:0]  sa;
    logic [5:0]  ca;
    logic        ra;
  } vec_t;

  vec_t vt [80];
  int   nv = 0;

  direct_sound_fifo dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .addr        (addr),
    .wdata       (wdata),
    .size        (size),
    .wen         (wen),
    .mem_wait    (mem_wait),
    .soundcnt_h  (soundcnt_h),
    .timer0_ovf  (timer0_ovf),
    .timer1_ovf  (timer1_ovf),
    .sample_a    (sample_a),
    .sample_b    (sample_b),
    .sound_req_a (sound_req_a),
    .sound_req_b (sound_req_b),
    .sound_req   (sound_req),
    .count_a     (count_a),
    .count_b     (count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(op_e op, logic [31:0] d, logic [15:0] s,
                     logic [7:0] sa, logic [5:0] ca, logic ra);
    vt[nv].op   = op;
    vt[nv].data = d;
    vt[nv].sndh = s;
    vt[nv].sa   = sa;
    vt[nv].ca   = ca;
    vt[nv].ra   = ra;
    nv++;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(string tag, logic [7:0] esa, logic [5:0] eca, logic era,
                            logic [7:0] esb, logic [5:0] ecb, logic erb);
    chk({tag, " sample_a"},    {24'h0, sample_a},    {24'h0, esa});
    chk({tag, " count_a"},     {26'h0, count_a},     {26'h0, eca});
    chk({tag, " sound_req_a"}, {31'h0, sound_req_a}, {31'h0, era});
    chk({tag, " sample_b"},    {24'h0, sample_b},    {24'h0, esb});
    chk({tag, " count_b"},     {26'h0, count_b},     {26'h0, ecb});
    chk({tag, " sound_req_b"}, {31'h0, sound_req_b}, {31'h0, erb});
    chk({tag, " sound_req"},   {31'h0, sound_req},   {31'h0, era | erb});
  endtask

  task automatic drive(op_e op, logic [31:0] d, logic [15:0] s);
    wen        = 1'b0;
    addr       = 32'h0;
    size       = 2'b10;
    mem_wait   = 1'b0;
    timer0_ovf = 1'b0;
    timer1_ovf = 1'b0;
    wdata      = d;
    soundcnt_h = s;
    case (op)
      OP_WR_A:      begin wen = 1'b1; addr = 32'h0400_00A0; end
      OP_WR_B:      begin wen = 1'b1; addr = 32'h0400_00A4; end
      OP_POP0:      timer0_ovf = 1'b1;
      OP_POP1:      timer1_ovf = 1'b1;
      OP_WR_A_POP0: begin wen = 1'b1; addr = 32'h0400_00A0; timer0_ovf = 1'b1; end
      OP_WR_A_HALF: begin wen = 1'b1; addr = 32'h0400_00A0; size = 2'b01; end
      OP_WR_A_WAIT: begin wen = 1'b1; addr = 32'h0400_00A0; mem_wait = 1'b1; end
      OP_WR_BAD:    begin wen = 1'b1; addr = 32'h0400_00A8; end
      default:      wen = 1'b0;
    endcase
  endtask

  // One cycle: drive at the falling edge, let the rising edge act, check at the next falling edge.
  task automatic do_step(string tag, op_e op, logic [31:0] d, logic [15:0] s,
                         logic [7:0] esa, logic [5:0] eca, logic era,
                         logic [7:0] esb, logic [5:0] ecb, logic erb);
    drive(op, d, s);
    @(posedge clk);
    @(negedge clk);
    check_outs(tag, esa, eca, era, esb, ecb, erb);
  endtask

  initial begin
    logic [7:0] b;
    drive(OP_IDLE, 32'h0, 16'h0000);
    rst_b = 1'b0;

    // Channel A table
    add(OP_WR_A,      32'h8483_8281, 16'h0000, 8'h00, 6'd4, 1'b0);
    add(OP_POP0,      32'h0,         16'h0000, 8'h81, 6'd3, 1'b1);
    add(OP_POP0,      32'h0,         16'h0000, 8'h82, 6'd2, 1'b0);
    add(OP_POP0,      32'h0,         16'h0000, 8'h83, 6'd1, 1'b0);
    add(OP_POP0,      32'h0,         16'h0000, 8'h84, 6'd0, 1'b0);
    add(OP_POP0,      32'h0,         16'h0000, 8'h84, 6'd0, 1'b0);
    add(OP_WR_A_HALF, 32'h1111_1111, 16'h0000, 8'h84, 6'd0, 1'b0);
    add(OP_WR_A_WAIT, 32'h2222_2222, 16'h0000, 8'h84, 6'd0, 1'b0);
    add(OP_WR_BAD,    32'h3333_3333, 16'h0000, 8'h84, 6'd0, 1'b0);
    add(OP_WR_A,      32'h0403_0201, 16'h0000, 8'h84, 6'd4, 1'b0);
    add(OP_WR_A,      32'h0807_0605, 16'h0000, 8'h84, 6'd8, 1'b0);
    add(OP_WR_A,      32'h0C0B_0A09, 16'h0000, 8'h84, 6'd12, 1'b0);
    add(OP_WR_A,      32'h100F_0E0D, 16'h0000, 8'h84, 6'd16, 1'b0);
    add(OP_WR_A,      32'h1413_1211, 16'h0000, 8'h84, 6'd20, 1'b0);
    add(OP_POP0,      32'h0,         16'h0000, 8'h01, 6'd19, 1'b0);
    add(OP_POP0,      32'h0,         16'h0000, 8'h02, 6'd18, 1'b0);
    add(OP_POP0,      32'h0,         16'h0000, 8'h03, 6'd17, 1'b0);
    add(OP_POP0,      32'h0,         16'h0000, 8'h04, 6'd16, 1'b1);
    add(OP_POP0,      32'h0,         16'h0000, 8'h05, 6'd15, 1'b0);
    add(OP_POP0,      32'h0,         16'h0000, 8'h06, 6'd14, 1'b0);
    add(OP_WR_A,      32'h1817_1615, 16'h0000, 8'h06, 6'd18, 1'b0);
    add(OP_POP0,      32'h0,         16'h0000, 8'h07, 6'd17, 1'b0);
    add(OP_POP0,      32'h0,         16'h0000, 8'h08, 6'd16, 1'b1);
    for (int k = 0; k < 8; k++)
      add(OP_POP0, 32'h0, 16'h0000, 8'(8'h09 + k), 6'(15 - k), 1'b0);
    add(OP_WR_A_POP0, 32'h1C1B_1A19, 16'h0000, 8'h11, 6'd11, 1'b0);
    add(OP_WR_A,      32'h201F_1E1D, 16'h0000, 8'h11, 6'd15, 1'b0);
    add(OP_WR_A,      32'h2423_2221, 16'h0000, 8'h11, 6'd19, 1'b0);
    add(OP_WR_A,      32'h2827_2625, 16'h0000, 8'h11, 6'd23, 1'b0);
    add(OP_WR_A,      32'h2C2B_2A29, 16'h0000, 8'h11, 6'd27, 1'b0);
    add(OP_POP0,      32'h0,         16'h0000, 8'h12, 6'd26, 1'b0);
    add(OP_POP0,      32'h0,         16'h0000, 8'h13, 6'd25, 1'b0);
    add(OP_WR_A,      32'h302F_2E2D, 16'h0000, 8'h13, 6'd29, 1'b0);
    add(OP_WR_A,      32'hDEAD_BEEF, 16'h0000, 8'h13, 6'd29, 1'b0);
    add(OP_POP0,      32'h0,         16'h0000, 8'h14, 6'd28, 1'b0);
    add(OP_WR_A,      32'h3433_3231, 16'h0000, 8'h14, 6'd32, 1'b0);
    add(OP_WR_A,      32'hCAFE_F00D, 16'h0000, 8'h14, 6'd32, 1'b0);
    add(OP_IDLE,      32'h0,         16'h0800, 8'h00, 6'd0, 1'b0);
    add(OP_WR_A,      32'h0000_0099, 16'h0800, 8'h00, 6'd0, 1'b0);
    add(OP_POP0,      32'h0,         16'h0800, 8'h00, 6'd0, 1'b0);
    add(OP_WR_A,      32'h0000_0055, 16'h0000, 8'h00, 6'd4, 1'b0);
    add(OP_POP0,      32'h0,         16'h0000, 8'h55, 6'd3, 1'b1);
    add(OP_POP0,      32'h0,         16'h0000, 8'h00, 6'd2, 1'b0);
    add(OP_POP0,      32'h0,         16'h0000, 8'h00, 6'd1, 1'b0);
    add(OP_POP0,      32'h0,         16'h0000, 8'h00, 6'd0, 1'b0);

    repeat (2) @(negedge clk);
    check_outs("reset", 8'h00, 6'd0, 1'b0, 8'h00, 6'd0, 1'b0);
    rst_b = 1'b1;

    for (int i = 0; i < nv; i++)
      do_step($sformatf("vec%0d", i), vt[i].op, vt[i].data, vt[i].sndh,
              vt[i].sa, vt[i].ca, vt[i].ra, 8'h00, 6'd0, 1'b0);

    // Channel B on timer1: fill, overflow write, ignore timer0, drain with wrap
    for (int w = 0; w < 8; w++) begin
      b = 8'(8'hA0 + 4 * w);
      do_step($sformatf("b_fill%0d", w), OP_WR_B, {b + 8'd3, b + 8'd2, b + 8'd1, b}, 16'h4000,
              8'h00, 6'd0, 1'b0, 8'h00, 6'(4 * (w + 1)), 1'b0);
    end
    do_step("b_ninth", OP_WR_B, 32'h5555_5555, 16'h4000, 8'h00, 6'd0, 1'b0, 8'h00, 6'd32, 1'b0);
    do_step("b_t0",    OP_POP0, 32'h0,         16'h4000, 8'h00, 6'd0, 1'b0, 8'h00, 6'd32, 1'b0);
    for (int i = 0; i < 32; i++)
      do_step($sformatf("b_pop%0d", i), OP_POP1, 32'h0, 16'h4000,
              8'h00, 6'd0, 1'b0, 8'(8'hA0 + i), 6'(31 - i), (i == 15) ? 1'b1 : 1'b0);
    do_step("b_wrap_wr",  OP_WR_B, 32'h1312_1110, 16'h4000, 8'h00, 6'd0, 1'b0, 8'hBF, 6'd4, 1'b0);
    do_step("b_wrap_pop", OP_POP1, 32'h0,         16'h4000, 8'h00, 6'd0, 1'b0, 8'h10, 6'd3, 1'b1);

    // Channel B reset while partly full
    do_step("b_half1", OP_WR_B, 32'h0101_0101, 16'h4000, 8'h00, 6'd0, 1'b0, 8'h10, 6'd7, 1'b0);
    do_step("b_half2", OP_WR_B, 32'h0202_0202, 16'h4000, 8'h00, 6'd0, 1'b0, 8'h10, 6'd11, 1'b0);
    do_step("b_half3", OP_WR_B, 32'h0303_0303, 16'h4000, 8'h00, 6'd0, 1'b0, 8'h10, 6'd15, 1'b0);
    do_step("b_rst",     OP_IDLE, 32'h0,         16'hC000, 8'h00, 6'd0, 1'b0, 8'h00, 6'd0, 1'b0);
    do_step("b_rst_wr",  OP_WR_B, 32'h9999_9999, 16'hC000, 8'h00, 6'd0, 1'b0, 8'h00, 6'd0, 1'b0);
    do_step("b_rst_pop", OP_POP1, 32'h0,         16'hC000, 8'h00, 6'd0, 1'b0, 8'h00, 6'd0, 1'b0);
    do_step("b_post_wr",  OP_WR_B, 32'h7766_5544, 16'h4000, 8'h00, 6'd0, 1'b0, 8'h00, 6'd4, 1'b0);
    do_step("b_post_pop", OP_POP1, 32'h0,         16'h4000, 8'h00, 6'd0, 1'b0, 8'h44, 6'd3, 1'b1);

    // Both channels on timer1, both requesting in the same cycle
    do_step("ab_wr_a", OP_WR_A, 32'h0000_00AA, 16'h4400, 8'h00, 6'd4, 1'b0, 8'h44, 6'd3, 1'b0);
    do_step("ab_wr_b", OP_WR_B, 32'h0000_00BB, 16'h4400, 8'h00, 6'd4, 1'b0, 8'h44, 6'd7, 1'b0);
    do_step("ab_pop",  OP_POP1, 32'h0,         16'h4400, 8'hAA, 6'd3, 1'b1, 8'h55, 6'd6, 1'b1);

    // Asynchronous reset between clock edges
    drive(OP_IDLE, 32'h0, 16'h0000);
    #2 rst_b = 1'b0;
    #1 check_outs("async_rst", 8'h00, 6'd0, 1'b0, 8'h00, 6'd0, 1'b0);
    #10 rst_b = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
